maple_rx_deserializer: RTL and testbench

//  Maple bus receive deserializer: sits between the line edge detector and the frame consumer, alongside end_frame_decoder.

---
 rtl/maple_rx_deserializer.sv | 140 ++++++++++++++
 tb/tb_maple_rx_deserializer.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maple_rx_deserializer.sv
// Maple bus receive deserializer: samples data on alternating SDCKA/SDCKB falling edges,
// packs bits MSB-first into bytes and reports frame completion or abort.
module maple_rx_deserializer #(
    parameter int MAX_BYTES      = 1024,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_sdcka,
    input  logic             i_sdckb,
    input  logic             i_sdcka_negedge,
    input  logic             i_sdckb_negedge,
    input  logic             i_start_frame,
    input  logic             i_end_frame,
    input  logic             i_end_frame_error,
    output logic [7:0]       o_rx_data,
    output logic             o_rx_valid,
    output logic             o_frame_active,
    output logic [CNT_W-1:0] o_byte_count,
    output logic             o_frame_done,
    output logic             o_frame_error
);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PHASE_A = 2'd1,
        PHASE_B = 2'd2
    } state_t;

    state_t           r_state, w_state_next;
    logic [2:0]       r_bit_cnt, w_bit_cnt_next;
    logic [7:0]       r_shift, w_shift_next;
    logic [7:0]       r_rx_data, w_rx_data_next;
    logic [TMR_W-1:0] r_timer, w_timer_next;
    logic [CNT_W-1:0] r_byte_count, w_byte_count_next;
    logic             r_rx_valid, w_rx_valid_next;
    logic             r_frame_done, w_frame_done_next;
    logic             r_frame_error, w_frame_error_next;

    logic w_active;
    logic w_edge;
    logic w_bit;
    logic w_timeout;

    assign w_active  = (r_state != IDLE);
    // Only the edge expected in the current phase counts; the other line is settling data.
    assign w_edge    = ((r_state == PHASE_A) && i_sdcka_negedge) ||
                       ((r_state == PHASE_B) && i_sdckb_negedge);
    assign w_bit     = (r_state == PHASE_A) ? i_sdckb : i_sdcka;
    assign w_timeout = (r_timer == TMR_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_bit_cnt     <= '0;
            r_shift       <= '0;
            r_rx_data     <= '0;
            r_timer       <= '0;
            r_byte_count  <= '0;
            r_rx_valid    <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_bit_cnt     <= w_bit_cnt_next;
            r_shift       <= w_shift_next;
            r_rx_data     <= w_rx_data_next;
            r_timer       <= w_timer_next;
            r_byte_count  <= w_byte_count_next;
            r_rx_valid    <= w_rx_valid_next;
            r_frame_done  <= w_frame_done_next;
            r_frame_error <= w_frame_error_next;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_bit_cnt_next     = r_bit_cnt;
        w_shift_next       = r_shift;
        w_rx_data_next     = r_rx_data;
        w_timer_next       = r_timer;
        w_byte_count_next  = r_byte_count;
        w_rx_valid_next    = 1'b0;
        w_frame_done_next  = 1'b0;
        w_frame_error_next = 1'b0;

        if (i_start_frame) begin
            // A start while a frame is open aborts that frame before restarting.
            w_frame_error_next = w_active;
            w_state_next       = PHASE_A;
            w_bit_cnt_next     = '0;
            w_shift_next       = '0;
            w_timer_next       = '0;
            w_byte_count_next  = '0;
        end else if (w_active) begin
            if (i_end_frame_error) begin
                w_frame_error_next = 1'b1;
                w_state_next       = IDLE;
            end else if (i_end_frame) begin
                // The end pattern leaves exactly one stray PHASE_A bit behind a clean frame.
                if (r_bit_cnt == 3'd1) begin
                    w_frame_done_next = 1'b1;
                end else begin
                    w_frame_error_next = 1'b1;
                end
                w_state_next = IDLE;
            end else if (w_timeout) begin
                w_frame_error_next = 1'b1;
                w_state_next       = IDLE;
            end else if (w_edge) begin
                w_timer_next   = '0;
                w_shift_next   = {r_shift[6:0], w_bit};
                w_bit_cnt_next = r_bit_cnt + 3'd1;
                w_state_next   = (r_state == PHASE_A) ? PHASE_B : PHASE_A;
                if (r_bit_cnt == 3'd7) begin
                    if (r_byte_count == CNT_W'(MAX_BYTES)) begin
                        w_frame_error_next = 1'b1;
                        w_state_next       = IDLE;
                    end else begin
                        w_rx_data_next    = {r_shift[6:0], w_bit};
                        w_rx_valid_next   = 1'b1;
                        w_byte_count_next = r_byte_count + CNT_W'(1);
                    end
                end
            end else begin
                w_timer_next = r_timer + TMR_W'(1);
            end
        end
    end

    assign o_rx_data      = r_rx_data;
    assign o_rx_valid     = r_rx_valid;
    assign o_frame_active = w_active;
    assign o_byte_count   = r_byte_count;
    assign o_frame_done   = r_frame_done;
    assign o_frame_error  = r_frame_error;

endmodule

// File: tb/tb_maple_rx_deserializer.sv
// Bench for maple_rx_deserializer: directed vector table, hand-written corner sequences,
// and random frames scored against a frame-level reference model.
module tb_maple_rx_deserializer;
    localparam int MAX_BYTES = 4;
    localparam int TIMEOUT   = 16;
    localparam int CNT_W     = 11;
    localparam int K_END     = 0;
    localparam int K_ERR     = 1;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             i_sdcka = 1'b1, i_sdckb = 1'b1;
    logic             i_sdcka_negedge = 1'b0, i_sdckb_negedge = 1'b0;
    logic             i_start_frame = 1'b0, i_end_frame = 1'b0, i_end_frame_error = 1'b0;
    logic [7:0]       o_rx_data;
    logic             o_rx_valid, o_frame_active, o_frame_done, o_frame_error;
    logic [CNT_W-1:0] o_byte_count;

    maple_rx_deserializer #(
        .MAX_BYTES(MAX_BYTES), .TIMEOUT_CYCLES(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .i_sdcka(i_sdcka), .i_sdckb(i_sdckb),
        .i_sdcka_negedge(i_sdcka_negedge), .i_sdckb_negedge(i_sdckb_negedge),
        .i_start_frame(i_start_frame), .i_end_frame(i_end_frame),
        .i_end_frame_error(i_end_frame_error),
        .o_rx_data(o_rx_data), .o_rx_valid(o_rx_valid), .o_frame_active(o_frame_active),
        .o_byte_count(o_byte_count), .o_frame_done(o_frame_done), .o_frame_error(o_frame_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] got_q[$];
    int done_total = 0, err_total = 0, overlap_total = 0;

    always @(negedge clk) begin
        if (reset) begin
            if (o_rx_valid) got_q.push_back(o_rx_data);
            if (o_frame_done) done_total++;
            if (o_frame_error) err_total++;
            if (int'(o_rx_valid) + int'(o_frame_done) + int'(o_frame_error) > 1) overlap_total++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [47:0] pbits;
        int          nbits;
        int          kind;
        int          exp_n;
        logic [39:0] exp_bytes;
        int          exp_done;
        int          exp_err;
        int          exp_cnt;
    } vec_t;
    vec_t vecs[8];

    bit         frame_bits[64];
    int         nbits;
    logic [7:0] exp_q[$];
    int         exp_done, exp_err, exp_cnt;
    int         base_n, base_done, base_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mark();
        base_n    = got_q.size();
        base_done = done_total;
        base_err  = err_total;
    endtask

    task automatic pulse_start();
        i_start_frame = 1'b1;
        cyc();
        i_start_frame = 1'b0;
    endtask

    task automatic load_bits(input logic [47:0] p, input int n);
        nbits = n;
        for (int i = 0; i < n; i++) frame_bits[i] = p[n-1-i];
    endtask

    // Even bits go out on SDCKA falls (data on SDCKB), odd bits on SDCKB falls.
    task automatic send_bit(input int k, input bit b, input int gap);
        if (k % 2 == 0) begin
            i_sdckb = b; i_sdcka = ~b; i_sdcka_negedge = 1'b1;
        end else begin
            i_sdcka = b; i_sdckb = ~b; i_sdckb_negedge = 1'b1;
        end
        cyc();
        i_sdcka_negedge = 1'b0;
        i_sdckb_negedge = 1'b0;
        for (int g = 0; g < gap; g++) begin
            if ($urandom_range(0, 1) == 1) begin
                if (k % 2 == 0) i_sdcka_negedge = 1'b1;
                else            i_sdckb_negedge = 1'b1;
            end
            i_sdcka = 1'($urandom_range(0, 1));
            i_sdckb = 1'($urandom_range(0, 1));
            cyc();
            i_sdcka_negedge = 1'b0;
            i_sdckb_negedge = 1'b0;
        end
    endtask

    task automatic send_bits(input int n, input int maxgap);
        for (int k = 0; k < n; k++) send_bit(k, frame_bits[k], int'($urandom_range(0, maxgap)));
    endtask

    task automatic finish_frame(input int kind);
        if (kind == K_END) i_end_frame = 1'b1;
        else               i_end_frame_error = 1'b1;
        cyc();
        i_end_frame       = 1'b0;
        i_end_frame_error = 1'b0;
        repeat (3) cyc();
    endtask

    task automatic check_frame(input string name);
        int n;
        n = got_q.size() - base_n;
        check({name, ".n_bytes"}, n, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < n; i++)
            check($sformatf("%s.byte%0d", name, i), 32'(got_q[base_n + i]), 32'(exp_q[i]));
        check({name, ".frame_done"}, done_total - base_done, exp_done);
        check({name, ".frame_error"}, err_total - base_err, exp_err);
        check({name, ".byte_count"}, 32'(o_byte_count), exp_cnt);
        check({name, ".frame_active"}, 32'(o_frame_active), 0);
        $display("%s: bits=%0d bytes=%0d done=%0d err=%0d byte_count=%0d", name, nbits, n,
                 done_total - base_done, err_total - base_err, o_byte_count);
    endtask

    // Frame-level reference: whole bytes from the bit stream, capped at MAX_BYTES.
    task automatic model_expect(input int kind);
        int complete;
        logic [7:0] b;
        complete = nbits / 8;
        exp_q.delete();
        for (int i = 0; i < complete && i < MAX_BYTES; i++) begin
            b = 8'h00;
            for (int j = 0; j < 8; j++) b = {b[6:0], frame_bits[8*i + j]};
            exp_q.push_back(b);
        end
        exp_done = 0;
        exp_err  = 0;
        if (complete > MAX_BYTES) begin
            exp_err = 1;
            exp_cnt = MAX_BYTES;
        end else begin
            exp_cnt = complete;
            if (kind == K_END && nbits % 8 == 1) exp_done = 1;
            else                                 exp_err  = 1;
        end
    endtask

    initial begin
        int lat;
        logic act_before;
        int kind;
        int nb, extra;

        vecs[0] = '{48'h14B,        9,  K_END, 1, 40'hA5,         1, 0, 1};
        vecs[1] = '{48'h2468ACF0,   33, K_END, 4, 40'h12345678,   1, 0, 4};
        vecs[2] = '{48'h15,         5,  K_END, 0, 40'h0,          0, 1, 0};
        vecs[3] = '{48'h14B,        9,  K_ERR, 1, 40'hA5,         0, 1, 1};
        vecs[4] = '{48'hC3,         8,  K_END, 1, 40'hC3,         0, 1, 1};
        vecs[5] = '{48'h0102030405, 40, K_END, 4, 40'h01020304,   0, 1, 4};
        vecs[6] = '{48'h1,          1,  K_END, 0, 40'h0,          1, 0, 0};
        vecs[7] = '{48'h7903,       17, K_END, 2, 40'h3C81,       1, 0, 2};

        #12;
        check("reset.rx_data", 32'(o_rx_data), 0);
        check("reset.rx_valid", 32'(o_rx_valid), 0);
        check("reset.frame_active", 32'(o_frame_active), 0);
        check("reset.byte_count", 32'(o_byte_count), 0);
        check("reset.frame_done", 32'(o_frame_done), 0);
        check("reset.frame_error", 32'(o_frame_error), 0);
        @(negedge clk);
        reset = 1'b1;
        cyc();

        for (int v = 0; v < 8; v++) begin
            load_bits(vecs[v].pbits, vecs[v].nbits);
            mark();
            pulse_start();
            check($sformatf("vec%0d.active_after_start", v), 32'(o_frame_active), 1);
            send_bits(nbits, 3);
            finish_frame(vecs[v].kind);
            exp_q.delete();
            for (int i = 0; i < vecs[v].exp_n; i++)
                exp_q.push_back(vecs[v].exp_bytes[8*(vecs[v].exp_n-1-i) +: 8]);
            exp_done = vecs[v].exp_done;
            exp_err  = vecs[v].exp_err;
            exp_cnt  = vecs[v].exp_cnt;
            check_frame($sformatf("vec%0d", v));
        end

        // Timeout with no edges at all after start.
        mark();
        nbits = 0;
        pulse_start();
        lat = 0;
        act_before = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            cyc();
            if (k == TIMEOUT - 1) act_before = o_frame_active;
            if (o_frame_error) begin
                lat = k;
                break;
            end
        end
        check("timeout0.latency", lat, TIMEOUT);
        check("timeout0.active_before", 32'(act_before), 1);
        cyc();
        check("timeout0.active_after", 32'(o_frame_active), 0);
        $display("timeout0: latency=%0d", lat);

        // Timeout measured from the last sampled edge.
        load_bits(48'h5, 3);
        mark();
        pulse_start();
        send_bits(3, 0);
        lat = 0;
        for (int k = 1; k <= 60; k++) begin
            cyc();
            if (o_frame_error) begin
                lat = k;
                break;
            end
        end
        check("timeout3.latency", lat, TIMEOUT);
        repeat (2) cyc();
        check("timeout3.errors", err_total - base_err, 1);
        check("timeout3.no_bytes", got_q.size() - base_n, 0);
        $display("timeout3: latency=%0d", lat);

        // End pulse landing on an expected edge drops that edge.
        load_bits(48'h5A, 8);
        mark();
        pulse_start();
        send_bits(8, 2);
        i_sdckb = 1'b1; i_sdcka = 1'b0;
        i_sdcka_negedge = 1'b1;
        i_end_frame = 1'b1;
        cyc();
        i_sdcka_negedge = 1'b0;
        i_end_frame = 1'b0;
        repeat (3) cyc();
        exp_q.delete();
        exp_q.push_back(8'h5A);
        exp_done = 0; exp_err = 1; exp_cnt = 1;
        check_frame("end_on_edge");

        // Restart mid-byte, then a fresh 0x3C.
        load_bits(48'h16, 5);
        mark();
        pulse_start();
        send_bits(5, 2);
        pulse_start();
        cyc();
        check("restart.abort_error", err_total - base_err, 1);
        check("restart.count_cleared", 32'(o_byte_count), 0);
        load_bits(48'h078, 9);
        send_bits(9, 2);
        finish_frame(K_END);
        exp_q.delete();
        exp_q.push_back(8'h3C);
        exp_done = 1; exp_err = 1; exp_cnt = 1;
        check_frame("restart");

        // Asynchronous reset mid-byte.
        load_bits(48'hA5A, 12);
        pulse_start();
        send_bits(12, 2);
        check("midreset.pre_count", 32'(o_byte_count), 1);
        #2 reset = 1'b0;
        #1;
        check("midreset.rx_data", 32'(o_rx_data), 0);
        check("midreset.rx_valid", 32'(o_rx_valid), 0);
        check("midreset.frame_active", 32'(o_frame_active), 0);
        check("midreset.byte_count", 32'(o_byte_count), 0);
        check("midreset.frame_done", 32'(o_frame_done), 0);
        check("midreset.frame_error", 32'(o_frame_error), 0);
        #2 reset = 1'b1;
        cyc();
        mark();
        i_end_frame = 1'b1;
        cyc();
        i_end_frame = 1'b0;
        i_end_frame_error = 1'b1;
        cyc();
        i_end_frame_error = 1'b0;
        repeat (3) cyc();
        check("idle_ignores_end.done", done_total - base_done, 0);
        check("idle_ignores_end.error", err_total - base_err, 0);
        $display("midreset: outputs cleared, idle ignores end pulses");

        // Random frames against the reference model.
        for (int f = 0; f < 40; f++) begin
            nb = int'($urandom_range(0, MAX_BYTES + 1));
            extra = ($urandom_range(0, 9) < 7) ? 1 : int'($urandom_range(0, 7));
            nbits = nb * 8 + extra;
            for (int i = 0; i < nbits; i++) frame_bits[i] = bit'($urandom_range(0, 1));
            kind = ($urandom_range(0, 5) == 0) ? K_ERR : K_END;
            model_expect(kind);
            mark();
            pulse_start();
            send_bits(nbits, 3);
            finish_frame(kind);
            check_frame($sformatf("rand%0d", f));
        end

        check("status_exclusive", overlap_total, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
